// File: rtl/panel_debounce.sv
// Front-panel input conditioner: per-channel sync, debounce, polarity fix,
// press/release pulses and optional auto-repeat. Outputs are all registered.

module panel_debounce_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE      = 50000,
    parameter int RPT_DELAY   = 25_000_000,
    parameter int RPT_PERIOD  = 5_000_000,
    parameter bit POL_BIT     = 1'b0,
    parameter bit RPT_BIT     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic srst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam int CW = $clog2(STABLE) + 1;
    localparam int DW = $clog2(RPT_DELAY) + 1;
    localparam int PW = $clog2(RPT_PERIOD) + 1;
    localparam int RW = (DW > PW) ? DW : PW;

    // Terminal counts are "minus one": the edge that sees this value is the
    // Nth edge, so acceptance/pulse happens on that same edge.
    localparam logic [CW-1:0] STABLE_M1 = CW'(STABLE - 1);
    localparam logic [RW-1:0] DELAY_M1  = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_M1 = RW'(RPT_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rpt_state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          rcnt_q;
    logic                   level_q, press_q, release_q;
    rpt_state_e             state_q;
    logic                   s, accept, rise, fall;

    // Synchroniser chain; polarity is corrected before the first flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     sync_q <= '0;
        else if (srst_i) sync_q <= '0;
        else             sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i ^ POL_BIT};
    end

    // Debounce decision: accept once the mismatch has lasted STABLE edges.
    always_comb begin
        s      = sync_q[SYNC_STAGES-1];
        accept = (s != level_q) && (cnt_q == STABLE_M1);
        rise   = accept & s;
        fall   = accept & ~s;
        cnt_d  = cnt_q + CW'(1);
        if (s == level_q || accept) cnt_d = '0;
    end

    // Level, edge pulses and the auto-repeat FSM; a fall beats a repeat pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            rcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= S_IDLE;
        end else if (srst_i) begin
            cnt_q     <= '0;
            rcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= S_IDLE;
        end else begin
            cnt_q     <= cnt_d;
            press_q   <= rise;
            release_q <= fall;
            if (accept) level_q <= s;
            case (state_q)
                S_IDLE: begin
                    if (rise && RPT_BIT) begin
                        state_q <= S_DELAY;
                        rcnt_q  <= '0;
                    end
                end
                S_DELAY: begin
                    if (fall) begin
                        state_q <= S_IDLE;
                    end else if (rcnt_q == DELAY_M1) begin
                        press_q <= 1'b1;
                        state_q <= S_REPEAT;
                        rcnt_q  <= '0;
                    end else begin
                        rcnt_q  <= rcnt_q + RW'(1);
                    end
                end
                S_REPEAT: begin
                    if (fall) begin
                        state_q <= S_IDLE;
                    end else if (rcnt_q == PERIOD_M1) begin
                        press_q <= 1'b1;
                        rcnt_q  <= '0;
                    end else begin
                        rcnt_q  <= rcnt_q + RW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
endmodule

module panel_debounce #(
    parameter int             NCH         = 7,
    parameter int             SYNC_STAGES = 2,
    parameter int             STABLE      = 50000,
    parameter logic [NCH-1:0] POL         = '0,
    parameter logic [NCH-1:0] RPT_EN      = '0,
    parameter int             RPT_DELAY   = 25_000_000,
    parameter int             RPT_PERIOD  = 5_000_000
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           srst_i,
    input  logic [NCH-1:0] raw_i,
    output logic [NCH-1:0] level_o,
    output logic [NCH-1:0] press_o,
    output logic [NCH-1:0] release_o
);
    // One independent conditioner per channel; no arbitration between them.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        panel_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE      (STABLE),
            .RPT_DELAY   (RPT_DELAY),
            .RPT_PERIOD  (RPT_PERIOD),
            .POL_BIT     (POL[i]),
            .RPT_BIT     (RPT_EN[i])
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .srst_i    (srst_i),
            .raw_i     (raw_i[i]),
            .level_o   (level_o[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i])
        );
    end
endmodule

// File: tb/tb_panel_debounce.sv
// Directed bench for panel_debounce: NCH=4, STABLE=4, RPT_DELAY=10,
// RPT_PERIOD=3, repeat on ch1, inverted ch2.

module tb_panel_debounce;
    logic       clk = 1'b0;
    logic       rst_n, srst;
    logic [3:0] raw, level, press, rel;
    int         n_chk = 0;
    int         n_err = 0;

    panel_debounce #(
        .NCH(4), .SYNC_STAGES(2), .STABLE(4), .POL(4'b0100),
        .RPT_EN(4'b0010), .RPT_DELAY(10), .RPT_PERIOD(3)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .srst_i(srst), .raw_i(raw),
        .level_o(level), .press_o(press), .release_o(rel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, output logic [3:0] por, output logic [3:0] ror);
        por = '0;
        ror = '0;
        repeat (n) begin
            step();
            por |= press;
            ror |= rel;
        end
    endtask

    // Hold ch1 into REPEAT, clear (sync or async), then check full re-acquire.
    task automatic reacquire(input bit use_srst);
        logic [3:0] por, ror;
        raw[1] = 1'b1;
        repeat (21) step();
        if (use_srst) begin
            srst = 1'b1; step();
            chk("t5 clr", {level, press, rel}, 12'h000);
            srst = 1'b0;
        end else begin
            rst_n = 1'b0; step();
            chk("t5 clr", {level, press, rel}, 12'h000);
            rst_n = 1'b1;
        end
        for (int e = 1; e <= 16; e++) begin
            logic [3:0] ep, el;
            step();
            ep = (e == 6) ? 4'b0110 : (e == 16) ? 4'b0010 : 4'b0000;
            el = (e >= 6) ? 4'b0110 : 4'b0000;
            chk($sformatf("t5 s%0d e%0d", use_srst, e), {level, press, rel}, {el, ep, 4'b0000});
        end
        raw[1] = 1'b0;
        idle(8, por, ror);
        chk("t5 rel", ror, 4'b0010);
    endtask

    initial begin
        logic [3:0] por, ror;
        logic       lv;
        int         np;
        rst_n = 1'b0; srst = 1'b0; raw = 4'b0000;

        // 1. reset and polarity
        repeat (3) step();
        chk("rst level", level, 4'b0000);
        chk("rst press", press, 4'b0000);
        chk("rst rel", rel, 4'b0000);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk($sformatf("t1 e%0d", e), {level, press},
                (e == 6) ? 8'h44 : 8'h00);
        end
        idle(50, por, ror);
        chk("t1 quiet", {por, ror}, 8'h00);
        chk("t1 level", level, 4'b0100);

        // 2. glitch threshold
        raw[0] = 1'b1; repeat (3) step(); raw[0] = 1'b0;
        idle(10, por, ror);
        chk("t2 glitch", {level, por, ror}, 12'h400);
        raw[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 5) raw[0] = 1'b0;
            step();
            chk($sformatf("t2 e%0d", e), {rel[0], press[0], level[0]},
                {e == 10, e == 6, (e >= 6 && e < 10)});
        end

        // 3. bounce
        por = '0; lv = 1'b0;
        for (int c = 0; c < 20; c++) begin
            raw[3] = ((c / 2) % 2 == 0);
            step();
            por |= press;
            lv  |= level[3];
        end
        chk("t3 bounce", {lv, por[3]}, 2'b00);
        raw[3] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk($sformatf("t3 e%0d", e), {press[3], level[3]}, {e == 6, e == 6});
        end
        idle(10, por, ror);
        chk("t3 single", por[3], 1'b0);
        raw[3] = 1'b0;
        idle(8, por, ror);
        chk("t3 rel", ror, 4'b1000);

        // 4. auto-repeat on ch1, fall coincides with a repeat slot at t+46
        raw[1] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk($sformatf("t4 acc e%0d", e), press[1], e == 6);
        end
        for (int d = 1; d <= 60; d++) begin
            if (d == 41) raw[1] = 1'b0;
            step();
            chk($sformatf("t4 d%0d", d), {rel[1], press[1], level[1]},
                {d == 46, (d >= 10 && d < 46 && (d - 10) % 3 == 0), d < 46});
        end
        // no repeat on ch0
        raw[0] = 1'b1; np = 0;
        repeat (46) begin step(); np += int'(press[0]); end
        raw[0] = 1'b0;
        idle(10, por, ror);
        chk("t4 ch0 presses", np, 1);

        // 5. mid-operation reset, sync then async
        reacquire(1'b1);
        reacquire(1'b0);

        // 6. simultaneous edges
        raw = 4'b1011;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk($sformatf("t6 r e%0d", e), {press, rel}, (e == 6) ? 8'hB0 : 8'h00);
        end
        raw = 4'b0000;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk($sformatf("t6 f e%0d", e), {press, rel}, (e == 6) ? 8'h0B : 8'h00);
        end
        chk("t6 level", level, 4'b0100);
        idle(15, por, ror);
        chk("t6 quiet", {por, ror}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
